mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive data grants allowed while a fetch is pending before fetch is forced.
REQ-002 Parameter TIMEOUT, default 64: cycles in BUSY without mem_ack before abort.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 if_req  in  1  fetch-port request, held until if_ready.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_rdata  out  32  registered fetch read data.
REQ-008 if_ready  out  1  one-cycle pulse: fetch transaction complete.
REQ-009 dm_rd_en / dm_wr_en  in  1 each  data-port read/write request, held until dm_ready.
REQ-010 dm_addr, dm_wdata  in  32 each  data-port address and write data.
REQ-011 dm_rdata  out  32  registered data-port read data.
REQ-012 dm_ready  out  1  one-cycle pulse: data transaction complete (feeds memready_m).
REQ-013 mem_req  out  1  unified-memory request level.
REQ-014 mem_we  out  1  1 = write, 0 = read.
REQ-015 mem_addr, mem_wdata  out  32 each  latched address and write data.
REQ-016 mem_rdata  in  32  memory read data, valid with mem_ack.
REQ-017 mem_ack  in  1  one-cycle completion pulse from memory.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 FSM states: IDLE, BUSY_D, BUSY_I, DONE.
REQ-020 IDLE: if (dm_rd_en|dm_wr_en) and not starvation-forced -> latch dm_addr/dm_wdata/mem_we, go BUSY_D; else if if_req -> latch if_addr, mem_we=0, go BUSY_I; else stay.
REQ-021 Data port has priority over fetch (older instruction).
REQ-022 dm_wr_en and dm_rd_en both high: treated as a write.
REQ-023 Starvation: streak counter increments on each data grant made while if_req=1; resets to 0 on any fetch grant; when streak = STARVE_LIMIT and if_req=1 in IDLE, fetch is granted instead.
REQ-024 mem_req = 1 exactly while in BUSY_D or BUSY_I; mem_addr/mem_wdata/mem_we stable throughout.
REQ-025 BUSY_x with mem_ack=1: capture mem_rdata into dm_rdata (BUSY_D, reads only) or if_rdata (BUSY_I), go DONE.
REQ-026 DONE: assert the granted port's ready for exactly one cycle; ignore all requests; next state IDLE.
REQ-027 Minimum latency: request sampled in IDLE at cycle N, mem_req high N+1, ack at N+1 -> ready high N+2; next grant no earlier than N+3.
REQ-028 Write transactions leave dm_rdata unchanged.
REQ-029 Requester dropping its request mid-transaction: transaction still completes and ready still pulses.
REQ-030 mem_ack outside BUSY states: ignored.
REQ-031 Watchdog counter cleared on entering BUSY; at TIMEOUT cycles without ack: drop mem_req, set err=1, load 32'h0 into the granted port's rdata, go DONE (ready still pulses).
REQ-032 err remains 1 until reset; arbitration continues normally after a timeout.
REQ-033 if_ready and dm_ready never high in the same cycle.

Reset
REQ-034 reset=0 at a clock edge: state=IDLE, streak=0, watchdog=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, if_ready=0, dm_ready=0, err=0.
REQ-035 Reset mid-transaction aborts it without any ready pulse; mem_req falls at that edge.

Verification
REQ-036 Fetch only: if_req=1, if_addr=0x40, ack after 2 cycles with rdata 0x2002000A -> mem_req high 2 cycles, if_ready one pulse, if_rdata=0x2002000A.
REQ-037 Simultaneous: if_req and dm_rd_en (addr 0x100) in same IDLE cycle -> data served first (mem_addr=0x100, mem_we=0), fetch granted after the DONE cycle.
REQ-038 Starvation: if_req held, dm_rd_en held continuously, ack=1 cycle -> exactly 4 data grants, then 1 fetch grant, streak restarts.
REQ-039 Write: dm_wr_en, addr 0x20, wdata 0xCAFEF00D -> mem_we=1, mem_wdata=0xCAFEF00D, dm_ready pulse, dm_rdata unchanged.
REQ-040 Timeout: fetch granted, mem_ack never asserted -> after 64 BUSY cycles mem_req=0, err=1, if_rdata=0, if_ready pulse; subsequent transaction completes normally with err still 1.
REQ-041 Reset mid-BUSY_D: reset=0 for 1 cycle -> all outputs at reset values, no dm_ready pulse, late mem_ack ignored.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data ports onto one unified memory, with starvation guard and watchdog.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_rd_en,
  input  logic        dm_wr_en,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, DONE} state_t;
  state_t state;
  logic [SW-1:0] streak;
  logic [WW-1:0] wd;
  logic dm_any, force_if, timeout;
  assign dm_any = dm_rd_en | dm_wr_en;
  assign force_if = if_req && (streak >= SW'(STARVE_LIMIT));
  assign timeout = wd == WW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      streak <= '0;
      wd <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      err <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE:
          if (dm_any && !force_if) begin
            state <= BUSY_D;
            mem_req <= 1'b1;
            mem_we <= dm_wr_en;
            mem_addr <= dm_addr;
            mem_wdata <= dm_wdata;
            wd <= '0;
            if (if_req) streak <= streak + SW'(1);
          end else if (if_req) begin
            state <= BUSY_I;
            mem_req <= 1'b1;
            mem_we <= 1'b0;
            mem_addr <= if_addr;
            wd <= '0;
            streak <= '0;
          end
        BUSY_D, BUSY_I:
          if (mem_ack || timeout) begin
            // a timed-out transaction still completes, returning zero data
            state <= DONE;
            mem_req <= 1'b0;
            if (!mem_ack) err <= 1'b1;
            if (state == BUSY_I) begin
              if_ready <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              dm_ready <= 1'b1;
              if (!mem_we) dm_rdata <= mem_ack ? mem_rdata : '0;
            end
          end else begin
            wd <= wd + WW'(1);
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a delayed-ack memory responder for mem_arbiter.
module tb_mem_arbiter;
  logic clk, reset, if_req, if_ready, dm_rd_en, dm_wr_en, dm_ready;
  logic mem_req, mem_we, mem_ack, err;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic ack_en, stray_ack;
  int ack_dly, cnt, total, bad;
  typedef struct packed {logic d; logic [31:0] v;} exp_t;
  exp_t sb[$];

  mem_arbiter dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a * 32'h0080_0800 + 32'hA;
  endfunction

  // memory responder: acks on the ack_dly-th cycle of mem_req
  initial begin
    mem_ack = 0;
    mem_rdata = 0;
    cnt = 0;
    forever begin
      @(negedge clk);
      mem_ack = stray_ack;
      if (mem_req && ack_en) begin
        cnt++;
        if (cnt == ack_dly) begin
          mem_ack = 1;
          mem_rdata = rd_model(mem_addr);
        end
      end else cnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL sim_watchdog bound expired");
    $fatal(1);
  end

  task automatic wait_ready(output logic gi, output logic gd, output int cyc, output int rc);
    gi = 0; gd = 0; cyc = 0; rc = 0;
    while (cyc < 300 && !gi && !gd) begin
      @(negedge clk);
      cyc++;
      if (mem_req) rc++;
      gi = if_ready;
      gd = dm_ready;
    end
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (2) @(negedge clk);
    total++; if ({mem_req, mem_we, if_ready, dm_ready, err} !== 5'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=00000", {mem_req, mem_we, if_ready, dm_ready, err}); end
    total++; if ({mem_addr, mem_wdata} !== 64'h0) begin bad++; $display("FAIL reset_mem got=%h exp=0", {mem_addr, mem_wdata}); end
    total++; if ({if_rdata, dm_rdata} !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", {if_rdata, dm_rdata}); end
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_fetch;
    logic gi, gd; int cyc, rc; exp_t e;
    ack_dly = 2; if_req = 1; if_addr = 32'h40;
    sb.push_back(exp_t'{1'b0, 32'h2002000A});
    wait_ready(gi, gd, cyc, rc);
    if_req = 0;
    e = sb.pop_front();
    total++; if ({gd, gi} !== {e.d, ~e.d}) begin bad++; $display("FAIL fetch_port got=%b%b exp=%b%b", gd, gi, e.d, ~e.d); end
    total++; if (if_rdata !== e.v) begin bad++; $display("FAIL fetch_data got=%h exp=%h", if_rdata, e.v); end
    total++; if (rc !== 2) begin bad++; $display("FAIL fetch_req_len got=%0d exp=2", rc); end
    @(negedge clk);
    total++; if (if_ready !== 0) begin bad++; $display("FAIL fetch_pulse got=%b exp=0", if_ready); end
  endtask

  task automatic test_simultaneous;
    logic gi, gd; int cyc, rc; exp_t e;
    ack_dly = 1; if_req = 1; if_addr = 32'h80; dm_rd_en = 1; dm_addr = 32'h100;
    sb.push_back(exp_t'{1'b1, rd_model(32'h100)});
    sb.push_back(exp_t'{1'b0, rd_model(32'h80)});
    @(negedge clk);
    total++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h100}) begin bad++; $display("FAIL simul_grant got=%b%b %h exp=10 00000100", mem_req, mem_we, mem_addr); end
    for (int k = 0; k < 2; k++) begin
      wait_ready(gi, gd, cyc, rc);
      if (gd) dm_rd_en = 0;
      if (gi) if_req = 0;
      e = sb.pop_front();
      total++; if ({gd, gi} !== {e.d, ~e.d}) begin bad++; $display("FAIL simul_order%0d got=%b%b exp=%b%b", k, gd, gi, e.d, ~e.d); end
      total++; if ((e.d ? dm_rdata : if_rdata) !== e.v) begin bad++; $display("FAIL simul_data%0d got=%h exp=%h", k, e.d ? dm_rdata : if_rdata, e.v); end
    end
    dm_rd_en = 0; if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_starvation;
    logic gi, gd; int cyc, rc; exp_t e;
    ack_dly = 1; if_req = 1; if_addr = 32'h200; dm_rd_en = 1; dm_addr = 32'h300;
    for (int i = 0; i < 10; i++)
      sb.push_back(i % 5 == 4 ? exp_t'{1'b0, rd_model(32'h200)} : exp_t'{1'b1, rd_model(32'h300)});
    for (int i = 0; i < 10; i++) begin
      wait_ready(gi, gd, cyc, rc);
      if (i == 9) begin if_req = 0; dm_rd_en = 0; end
      e = sb.pop_front();
      total++; if ({gd, gi} !== {e.d, ~e.d}) begin bad++; $display("FAIL starve_order%0d got=%b%b exp=%b%b", i, gd, gi, e.d, ~e.d); end
      total++; if ((e.d ? dm_rdata : if_rdata) !== e.v) begin bad++; $display("FAIL starve_data%0d got=%h exp=%h", i, e.d ? dm_rdata : if_rdata, e.v); end
    end
    if_req = 0; dm_rd_en = 0;
    @(negedge clk);
  endtask

  task automatic test_write;
    logic gi, gd; int cyc, rc; exp_t e;
    ack_dly = 3; dm_rd_en = 1; dm_wr_en = 1; dm_addr = 32'h20; dm_wdata = 32'hCAFEF00D;
    sb.push_back(exp_t'{1'b1, rd_model(32'h300)});
    @(negedge clk);
    total++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h20, 32'hCAFEF00D}) begin bad++; $display("FAIL write_grant got=%b%b %h %h exp=11 00000020 cafef00d", mem_req, mem_we, mem_addr, mem_wdata); end
    wait_ready(gi, gd, cyc, rc);
    dm_rd_en = 0; dm_wr_en = 0;
    e = sb.pop_front();
    total++; if ({gd, gi} !== {e.d, ~e.d}) begin bad++; $display("FAIL write_port got=%b%b exp=%b%b", gd, gi, e.d, ~e.d); end
    total++; if (dm_rdata !== e.v) begin bad++; $display("FAIL write_rdata got=%h exp=%h", dm_rdata, e.v); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic gi, gd; int cyc, rc; exp_t e; logic seen;
    ack_dly = 1; dm_rd_en = 1; dm_addr = 32'h400;
    for (int k = 0; k < 3; k++) sb.push_back(exp_t'{1'b1, rd_model(32'h400)});
    for (int k = 0; k < 3; k++) begin
      wait_ready(gi, gd, cyc, rc);
      if (k == 2) dm_rd_en = 0;
      e = sb.pop_front();
      total++; if ({gd, gi} !== {e.d, ~e.d}) begin bad++; $display("FAIL b2b_port%0d got=%b%b exp=%b%b", k, gd, gi, e.d, ~e.d); end
      total++; if (cyc !== (k == 0 ? 2 : 3)) begin bad++; $display("FAIL b2b_latency%0d got=%0d exp=%0d", k, cyc, k == 0 ? 2 : 3); end
      total++; if (dm_rdata !== e.v) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", k, dm_rdata, e.v); end
    end
    @(negedge clk);
    stray_ack = 1; seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      stray_ack = 0;
      seen |= mem_req | if_ready | dm_ready;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL idle_ack_ignored got=%b exp=0", seen); end
  endtask

  task automatic test_timeout;
    logic gi, gd; int cyc, rc; exp_t e;
    total++; if (err !== 0) begin bad++; $display("FAIL err_pre got=%b exp=0", err); end
    ack_en = 0; if_req = 1; if_addr = 32'h500;
    sb.push_back(exp_t'{1'b0, 32'h0});
    wait_ready(gi, gd, cyc, rc);
    if_req = 0;
    e = sb.pop_front();
    total++; if ({gd, gi} !== {e.d, ~e.d}) begin bad++; $display("FAIL tmo_port got=%b%b exp=%b%b", gd, gi, e.d, ~e.d); end
    total++; if (rc !== 64) begin bad++; $display("FAIL tmo_req_len got=%0d exp=64", rc); end
    total++; if ({err, mem_req, if_rdata} !== {2'b10, e.v}) begin bad++; $display("FAIL tmo_state got=%b%b %h exp=10 %h", err, mem_req, if_rdata, e.v); end
    ack_en = 1; ack_dly = 1;
    @(negedge clk);
    dm_rd_en = 1; dm_addr = 32'h600;
    sb.push_back(exp_t'{1'b1, rd_model(32'h600)});
    wait_ready(gi, gd, cyc, rc);
    dm_rd_en = 0;
    e = sb.pop_front();
    total++; if ({gd, gi} !== {e.d, ~e.d}) begin bad++; $display("FAIL post_tmo_port got=%b%b exp=%b%b", gd, gi, e.d, ~e.d); end
    total++; if ({err, dm_rdata} !== {1'b1, e.v}) begin bad++; $display("FAIL post_tmo got=%b %h exp=1 %h", err, dm_rdata, e.v); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic seen;
    ack_en = 0; dm_rd_en = 1; dm_addr = 32'h700;
    repeat (2) @(negedge clk);
    total++; if ({mem_req, mem_addr} !== {1'b1, 32'h700}) begin bad++; $display("FAIL rmid_busy got=%b %h exp=1 00000700", mem_req, mem_addr); end
    reset = 0; dm_rd_en = 0;
    @(negedge clk);
    total++; if ({mem_req, dm_ready, if_ready, err} !== 4'b0) begin bad++; $display("FAIL rmid_ctl got=%b exp=0000", {mem_req, dm_ready, if_ready, err}); end
    total++; if ({mem_addr, dm_rdata, if_rdata} !== 96'h0) begin bad++; $display("FAIL rmid_regs got=%h exp=0", {mem_addr, dm_rdata, if_rdata}); end
    reset = 1; stray_ack = 1; seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      stray_ack = 0;
      seen |= mem_req | dm_ready | if_ready;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rmid_late_ack got=%b exp=0", seen); end
    ack_en = 1;
  endtask

  initial begin
    clk = 0; reset = 0; if_req = 0; if_addr = 0; dm_rd_en = 0; dm_wr_en = 0;
    dm_addr = 0; dm_wdata = 0; ack_en = 1; ack_dly = 1; stray_ack = 0;
    total = 0; bad = 0;
    test_reset;
    test_fetch;
    test_simultaneous;
    test_starvation;
    test_write;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
